// File: rtl/snoopy_sprite_renderer_if.sv
// Plot and pattern-ROM bus between the sprite renderer and its neighbours.
// The master side is the renderer: it issues ROM addresses and drives the
// VGA adapter plot strobe. The slave side is the ROM / VGA adapter.
interface snoopy_sprite_renderer_if;
    logic [5:0] sprite_addr;
    logic [2:0] sprite_data;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport master (
        output sprite_addr,
        output vga_x,
        output vga_y,
        output vga_colour,
        output vga_plot,
        input  sprite_data
    );

    modport slave (
        input  sprite_addr,
        input  vga_x,
        input  vga_y,
        input  vga_colour,
        input  vga_plot,
        output sprite_data
    );
endinterface

// File: rtl/snoopy_sprite_renderer.sv
// Snoopy sprite renderer: once per accepted frame tick, erases the previous
// sprite box and redraws the sprite at the new column, one pixel per clock.
// Erase pixels appear on the plot bus during the S_ERASE cycles. In S_DRAW the
// ROM address runs one cycle ahead of the scan index, so sprite_data for scan
// index k is present while the FSM sits on index k; the first S_DRAW cycle is
// therefore the one-cycle fill and the last draw pixel lands on the final
// S_DRAW cycle.
module snoopy_sprite_renderer #(
    parameter int       SPRITE_W    = 8,
    parameter int       SPRITE_H    = 8,
    parameter int       Y_POS       = 100,
    parameter int       SCREEN_W    = 160,
    parameter logic [2:0] BG_COLOUR   = 3'b111,
    parameter logic [2:0] TRANSPARENT = 3'b000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [7:0] snoopy_x,
    output logic       busy,
    snoopy_sprite_renderer_if.master bus
);

    localparam int NPIX  = SPRITE_W * SPRITE_H;
    localparam int IDX_W = $clog2(NPIX + 1);
    localparam logic [IDX_W-1:0] END_IDX   = IDX_W'(NPIX);
    localparam logic [5:0]       LAST_ADDR = 6'(NPIX - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ERASE = 2'd1,
        S_DRAW  = 2'd2
    } state_t;

    state_t             state_r;
    logic [IDX_W-1:0]   idx_r;
    logic [7:0]         old_x_r;
    logic [7:0]         new_x_r;
    logic               drawn_r;
    logic               busy_r;
    logic [5:0]         addr_r;
    logic [7:0]         vga_x_r;
    logic [6:0]         vga_y_r;
    logic [2:0]         colour_r;
    logic               plot_r;

    logic [IDX_W-1:0]   scan_idx_s;
    logic [7:0]         base_s;
    logic [8:0]         col_s;
    logic [6:0]         row_s;
    logic [8:0]         px_x_s;
    logic [6:0]         px_y_s;
    logic               clip_s;

    // Screen coordinate and clip flag of the pixel the scan is about to emit.
    always_comb begin
        scan_idx_s = {IDX_W{1'b0}};
        base_s     = old_x_r;
        case (state_r)
            S_ERASE: begin
                scan_idx_s = idx_r;
                base_s     = old_x_r;
            end
            S_DRAW: begin
                scan_idx_s = idx_r;
                base_s     = new_x_r;
            end
            default: begin
                scan_idx_s = {IDX_W{1'b0}};
                base_s     = old_x_r;
            end
        endcase
        col_s  = 9'(scan_idx_s % IDX_W'(SPRITE_W));
        row_s  = 7'(scan_idx_s / IDX_W'(SPRITE_W));
        px_x_s = {1'b0, base_s} + col_s;
        px_y_s = 7'(Y_POS) + row_s;
        clip_s = (px_x_s >= 9'(SCREEN_W));
    end

    // Control FSM with all plot-bus outputs registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= S_IDLE;
            idx_r    <= {IDX_W{1'b0}};
            old_x_r  <= 8'd0;
            new_x_r  <= 8'd0;
            drawn_r  <= 1'b0;
            busy_r   <= 1'b0;
            addr_r   <= 6'd0;
            vga_x_r  <= 8'd0;
            vga_y_r  <= 7'd0;
            colour_r <= 3'd0;
            plot_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    plot_r <= 1'b0;
                    if (frame_tick) begin
                        new_x_r <= snoopy_x;
                        if (drawn_r && (snoopy_x == old_x_r)) begin
                            state_r <= S_IDLE;
                        end else if (drawn_r) begin
                            // Present erase pixel 0 right away; idx_r names the next one.
                            state_r  <= S_ERASE;
                            busy_r   <= 1'b1;
                            idx_r    <= IDX_W'(1);
                            vga_x_r  <= px_x_s[7:0];
                            vga_y_r  <= px_y_s;
                            colour_r <= BG_COLOUR;
                            plot_r   <= ~clip_s;
                        end else begin
                            state_r <= S_DRAW;
                            busy_r  <= 1'b1;
                            idx_r   <= {IDX_W{1'b0}};
                            addr_r  <= 6'd1;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_ERASE: begin
                    if (idx_r == END_IDX) begin
                        state_r <= S_DRAW;
                        idx_r   <= {IDX_W{1'b0}};
                        plot_r  <= 1'b0;
                        addr_r  <= 6'd1;
                    end else begin
                        vga_x_r  <= px_x_s[7:0];
                        vga_y_r  <= px_y_s;
                        colour_r <= BG_COLOUR;
                        plot_r   <= ~clip_s;
                        idx_r    <= idx_r + IDX_W'(1);
                    end
                end
                S_DRAW: begin
                    if (idx_r == END_IDX) begin
                        state_r <= S_IDLE;
                        plot_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        old_x_r <= new_x_r;
                        drawn_r <= 1'b1;
                    end else begin
                        vga_x_r  <= px_x_s[7:0];
                        vga_y_r  <= px_y_s;
                        colour_r <= bus.sprite_data;
                        plot_r   <= (bus.sprite_data != TRANSPARENT) && !clip_s;
                        idx_r    <= idx_r + IDX_W'(1);
                        // Address leads the scan by one; park at 0 after the last fetch.
                        if (addr_r != 6'd0) begin
                            addr_r <= (addr_r == LAST_ADDR) ? 6'd0 : addr_r + 6'd1;
                        end else begin
                            addr_r <= 6'd0;
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    plot_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy            = busy_r;
    assign bus.sprite_addr = addr_r;
    assign bus.vga_x       = vga_x_r;
    assign bus.vga_y       = vga_y_r;
    assign bus.vga_colour  = colour_r;
    assign bus.vga_plot    = plot_r;

endmodule
